// File: rtl/pulp_fetch_prefetcher.sv
// Sequential instruction prefetcher: issues word fetches from a branch target over a
// req/gnt/rvalid port, keeps a bounded number of requests in flight and buffers returned
// words in a small FIFO drained by decode. Branches flush the buffer and discard any
// responses still in flight.
module pulp_fetch_prefetcher #(
  parameter int unsigned FetchAddrWidth = 32,
  parameter int unsigned FetchDataWidth = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned FifoDepth      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      branch_i,
  input  logic [FetchAddrWidth-1:0] branch_addr_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [FetchDataWidth-1:0] instr_rdata_o,
  output logic [FetchAddrWidth-1:0] instr_addr_o,
  output logic                      instr_err_o,
  output logic                      fetch_req_o,
  output logic [FetchAddrWidth-1:0] fetch_addr_o,
  input  logic                      fetch_gnt_i,
  input  logic                      fetch_rvalid_i,
  input  logic [FetchDataWidth-1:0] fetch_rdata_i,
  input  logic                      fetch_rerror_i,
  output logic                      busy_o
);

  localparam int unsigned ByteOffW = $clog2(FetchDataWidth / 8);
  localparam int unsigned PtrW     = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW     = $clog2(FifoDepth + MaxOutstanding + 1) + 1;

  localparam logic [FetchAddrWidth-1:0] AddrInc   = FetchAddrWidth'(FetchDataWidth / 8);
  localparam logic [FetchAddrWidth-1:0] AlignMask =
      ~(FetchAddrWidth'((64'd1 << ByteOffW) - 64'd1));
  localparam logic [CntW-1:0] MaxOut  = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] FifoDep = CntW'(FifoDepth);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(FifoDepth - 1);

  typedef enum logic [1:0] {StIdle, StRun, StBranchWait} state_e;

  state_e                    state_q, state_d;
  logic [FetchAddrWidth-1:0] addr_q, addr_d;
  logic [FetchAddrWidth-1:0] br_addr_q, br_addr_d;
  logic [FetchAddrWidth-1:0] rsp_addr_q, rsp_addr_d;
  logic [CntW-1:0]           outst_q, outst_d;
  logic [CntW-1:0]           disc_q, disc_d;
  logic [CntW-1:0]           fifo_cnt_q, fifo_cnt_d;
  logic                      req_hold_q, req_hold_d;
  logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;

  logic [FetchDataWidth-1:0] mem_data_q [FifoDepth];
  logic [FetchAddrWidth-1:0] mem_addr_q [FifoDepth];
  logic                      mem_err_q  [FifoDepth];

  logic                      w_credit;
  logic                      w_gnt;
  logic                      w_push;
  logic                      w_pop;
  logic [CntW-1:0]           w_gnt_ext;
  logic [CntW-1:0]           w_rv_ext;
  logic [FetchAddrWidth-1:0] w_target;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // A response that is not being discarded always has a reserved FIFO slot.
  assign w_credit  = (outst_q < MaxOut) && ((outst_q + fifo_cnt_q) < FifoDep);
  // Request is purely registered: a raised request is held via req_hold_q until granted.
  assign fetch_req_o   = req_hold_q || ((state_q == StRun) && w_credit);
  assign fetch_addr_o  = addr_q;
  assign w_gnt         = fetch_req_o && fetch_gnt_i;
  assign w_gnt_ext     = {{(CntW-1){1'b0}}, w_gnt};
  assign w_rv_ext      = {{(CntW-1){1'b0}}, fetch_rvalid_i};
  assign w_target      = branch_addr_i & AlignMask;
  assign w_push        = fetch_rvalid_i && (disc_q == '0) && !branch_i;
  assign w_pop         = instr_valid_o && instr_ready_i && !branch_i;
  assign outst_d       = outst_q + w_gnt_ext - w_rv_ext;
  assign busy_o        = (outst_q != '0) || fetch_req_o;

  assign instr_valid_o = (fifo_cnt_q != '0);
  assign instr_rdata_o = mem_data_q[rd_ptr_q];
  assign instr_addr_o  = mem_addr_q[rd_ptr_q];
  assign instr_err_o   = mem_err_q[rd_ptr_q];

  // Next-state: FSM, fetch/response addresses and discard bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    br_addr_d  = br_addr_q;
    rsp_addr_d = rsp_addr_q;
    req_hold_d = fetch_req_o && !fetch_gnt_i;
    disc_d     = disc_q;
    if (fetch_rvalid_i && (disc_q != '0)) disc_d = disc_q - CntW'(1);
    if (w_push) rsp_addr_d = rsp_addr_q + AddrInc;
    if (w_gnt) addr_d = addr_q + AddrInc;

    unique case (state_q)
      StIdle: begin
        if (branch_i) begin
          addr_d     = w_target;
          rsp_addr_d = w_target;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (branch_i) begin
          // Everything in flight, including a grant in this cycle, belongs to the old stream.
          disc_d = outst_q + w_gnt_ext - w_rv_ext;
          if (fetch_req_o && !fetch_gnt_i) begin
            br_addr_d = w_target;
            state_d   = StBranchWait;
          end else begin
            addr_d     = w_target;
            rsp_addr_d = w_target;
          end
        end
      end
      StBranchWait: begin
        if (branch_i) br_addr_d = w_target;
        if (w_gnt) begin
          disc_d     = disc_d + CntW'(1);
          addr_d     = branch_i ? w_target : br_addr_q;
          rsp_addr_d = branch_i ? w_target : br_addr_q;
          state_d    = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO occupancy; a branch flush overrides any push or pop in the same cycle.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (branch_i) begin
      fifo_cnt_d = '0;
    end else begin
      if (w_push) fifo_cnt_d = fifo_cnt_d + CntW'(1);
      if (w_pop)  fifo_cnt_d = fifo_cnt_d - CntW'(1);
    end
  end

  // Control state and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      br_addr_q  <= '0;
      rsp_addr_q <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      fifo_cnt_q <= '0;
      req_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      br_addr_q  <= br_addr_d;
      rsp_addr_q <= rsp_addr_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      fifo_cnt_q <= fifo_cnt_d;
      req_hold_q <= req_hold_d;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        mem_data_q[i] <= '0;
        mem_addr_q[i] <= '0;
        mem_err_q[i]  <= 1'b0;
      end
    end else if (branch_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push) begin
        mem_data_q[wr_ptr_q] <= fetch_rdata_i;
        mem_addr_q[wr_ptr_q] <= rsp_addr_q;
        mem_err_q[wr_ptr_q]  <= fetch_rerror_i;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (w_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

endmodule

// File: tb/tb_pulp_fetch_prefetcher.sv
// Randomized bench for pulp_fetch_prefetcher: a behavioural memory responder plus a
// stream-level reference model (requests and delivered words must follow the latest
// branch target sequentially, old-stream words must never appear).
module tb_pulp_fetch_prefetcher;
  localparam int unsigned MaxOut = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        instr_err_o;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_gnt_i = 1'b0;
  logic        fetch_rvalid_i = 1'b0;
  logic [31:0] fetch_rdata_i = '0;
  logic        fetch_rerror_i = 1'b0;
  logic        busy_o;

  pulp_fetch_prefetcher #(
    .FetchAddrWidth(32),
    .FetchDataWidth(32),
    .MaxOutstanding(MaxOut),
    .FifoDepth     (4)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_rdata_o (instr_rdata_o),
    .instr_addr_o  (instr_addr_o),
    .instr_err_o   (instr_err_o),
    .fetch_req_o   (fetch_req_o),
    .fetch_addr_o  (fetch_addr_o),
    .fetch_gnt_i   (fetch_gnt_i),
    .fetch_rvalid_i(fetch_rvalid_i),
    .fetch_rdata_i (fetch_rdata_i),
    .fetch_rerror_i(fetch_rerror_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } rsp_t;

  rsp_t        rq[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Stimulus knobs.
  int unsigned gnt_pct = 100, dly_min = 0, dly_max = 0, rdy_pct = 100;
  bit          do_branch = 1'b0;
  logic [31:0] br_target = '0;

  // Reference model state.
  bit          started = 1'b0, held_old = 1'b0, prev_pend = 1'b0;
  logic [31:0] prev_addr = '0, next_req = '0, exp_out = '0;
  int unsigned cyc = 0, pops = 0, grants = 0, err_seen = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (a[6:2] == 5'd3);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample just after, advance the model.
  task automatic step();
    logic [31:0] tgt;
    @(negedge clk_i);
    cyc++;
    branch_i      = do_branch;
    branch_addr_i = br_target;
    do_branch     = 1'b0;
    fetch_gnt_i   = fetch_req_o && ($urandom_range(99) < gnt_pct);
    if (rq.size() != 0 && rq[0].due <= cyc) begin
      fetch_rvalid_i = 1'b1;
      fetch_rdata_i  = word_of(rq[0].addr);
      fetch_rerror_i = err_of(rq[0].addr);
    end else begin
      fetch_rvalid_i = 1'b0;
      fetch_rdata_i  = $urandom;
      fetch_rerror_i = 1'($urandom_range(1));
    end
    instr_ready_i = ($urandom_range(99) < rdy_pct);
    #1;
    if (prev_pend) begin
      check_eq("req_held", fetch_req_o, 1);
      check_eq("addr_held", fetch_addr_o, prev_addr);
    end
    if (!started) check_eq("idle_no_req", fetch_req_o, 0);
    check_eq("busy", busy_o, (rq.size() != 0) || fetch_req_o);
    if (fetch_req_o && fetch_gnt_i) begin
      if (held_old) begin
        held_old = 1'b0;
      end else begin
        check_eq("req_addr", fetch_addr_o, next_req);
        next_req += 32'd4;
        grants++;
      end
      rq.push_back('{addr: fetch_addr_o, due: cyc + 1 + $urandom_range(dly_max, dly_min)});
      check_eq("outstanding", rq.size() <= MaxOut, 1);
    end
    if (fetch_rvalid_i) void'(rq.pop_front());
    if (instr_valid_o && instr_ready_i && !branch_i) begin
      check_eq("out_addr", instr_addr_o, exp_out);
      check_eq("out_data", instr_rdata_o, word_of(exp_out));
      check_eq("out_err", instr_err_o, err_of(exp_out));
      if (instr_err_o) err_seen++;
      exp_out += 32'd4;
      pops++;
    end
    if (branch_i) begin
      tgt = branch_addr_i & ~32'h3;
      if (fetch_req_o && !fetch_gnt_i) held_old = 1'b1;
      next_req = tgt;
      exp_out  = tgt;
      started  = 1'b1;
      grants   = 0;
    end
    prev_pend = fetch_req_o && !fetch_gnt_i;
    prev_addr = fetch_addr_o;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, fetch_req_o, 0);
    check_eq({tag, "_faddr"}, fetch_addr_o, 0);
    check_eq({tag, "_valid"}, instr_valid_o, 0);
    check_eq({tag, "_rdata"}, instr_rdata_o, 0);
    check_eq({tag, "_iaddr"}, instr_addr_o, 0);
    check_eq({tag, "_err"}, instr_err_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    int unsigned p0;
    int unsigned e0;
    int unsigned k;
    #2 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1 check_reset_outputs("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) step();

    // Zero-wait streaming from a branch.
    gnt_pct = 100; dly_min = 0; dly_max = 0; rdy_pct = 100;
    do_branch = 1'b1; br_target = 32'h1C00_0080;
    step();
    step();
    check_eq("t1_req_next", fetch_req_o, 1);
    check_eq("t1_addr_next", fetch_addr_o, 32'h1C00_0080);
    step();
    check_eq("t1_valid_early", instr_valid_o, 0);
    p0 = pops;
    step();
    check_eq("t1_valid_lat3", instr_valid_o, 1);
    check_eq("t1_first_addr", instr_addr_o, 32'h1C00_0080);
    repeat (15) step();
    check_eq("t1_rate", pops - p0, 16);

    // Branch away with two slow responses in flight.
    dly_min = 2; dly_max = 2;
    do_branch = 1'b1; br_target = 32'h100;
    step();
    k = 0;
    while (rq.size() != 2 && k < 12) begin
      step();
      k++;
    end
    check_eq("t2_two_inflight", rq.size(), 2);
    do_branch = 1'b1; br_target = 32'h400;
    p0 = pops;
    repeat (25) step();
    check_eq("t2_new_stream", pops - p0 > 0, 1);

    // Branch while a request is stalled without grant.
    dly_min = 0; dly_max = 1; gnt_pct = 0;
    do_branch = 1'b1; br_target = 32'h200;
    repeat (6) step();
    check_eq("t3_req", fetch_req_o, 1);
    check_eq("t3_addr", fetch_addr_o, 32'h200);
    do_branch = 1'b1; br_target = 32'h800;
    repeat (4) step();
    check_eq("t3_req_hold", fetch_req_o, 1);
    check_eq("t3_addr_hold", fetch_addr_o, 32'h200);
    gnt_pct = 100;
    p0 = pops;
    repeat (12) step();
    check_eq("t3_resumed", pops - p0 > 0, 1);

    // Consumer stall fills the buffer, then drains without gaps.
    dly_min = 0; dly_max = 0; rdy_pct = 0;
    do_branch = 1'b1; br_target = 32'h300;
    repeat (15) step();
    check_eq("t4_buffered", grants, 4);
    check_eq("t4_req_drop", fetch_req_o, 0);
    check_eq("t4_valid", instr_valid_o, 1);
    check_eq("t4_head", instr_addr_o, 32'h300);
    rdy_pct = 100;
    p0 = pops;
    repeat (16) step();
    check_eq("t4_no_gaps", pops - p0, 16);

    // Error on a single word.
    do_branch = 1'b1; br_target = 32'h100;
    e0 = err_seen;
    repeat (14) step();
    check_eq("t5_one_err", err_seen - e0, 1);
    check_eq("t5_continue", exp_out > 32'h110, 1);

    // Asynchronous reset in the middle of traffic.
    dly_min = 3; dly_max = 3; rdy_pct = 0;
    do_branch = 1'b1; br_target = 32'h500;
    repeat (6) step();
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("t6");
    rq.delete();
    started = 1'b0; held_old = 1'b0; prev_pend = 1'b0;
    fetch_gnt_i = 1'b0; fetch_rvalid_i = 1'b0; branch_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) step();
    check_eq("t6_quiet_busy", busy_o, 0);

    // Random traffic.
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        gnt_pct = $urandom_range(100, 30);
        dly_min = $urandom_range(1);
        dly_max = dly_min + $urandom_range(3);
        rdy_pct = $urandom_range(100, 20);
      end
      if ($urandom_range(99) < 3) begin
        do_branch = 1'b1;
        br_target = $urandom;
      end
      step();
    end
    check_eq("rand_live", pops - p0 > 200, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
